friscv_axi4_mem_slave: RTL and testbench
========================================

Name: friscv_axi4_mem_slave

Overview:
- AXI4 slave responder with internal byte-addressable memory; the target end of the data-cache AXI4 master interface.
- Accepts AW/W/AR requests from the cache side and answers on B/R.
- Used as central-memory model in block/system benches and as a small on-chip data RAM.
- Independent write and read engines, one outstanding transaction each, INCR/FIXED bursts up to 256 beats.

Parameters:
- AXI_ADDR_W, 16, AXI address width.
- AXI_ID_W, 8, AXI ID width.
- AXI_DATA_W, 128, data bus width; power of 2, >= 32.
- MEM_DEPTH, 1024, number of AXI_DATA_W-wide words; power of 2.

Ports:
- aclk  in  1  clock
- srst  in  1  synchronous active-high reset
- awvalid in 1 / awready out 1 / awaddr in AXI_ADDR_W / awlen in 8 / awsize in 3 / awburst in 2 / awid in AXI_ID_W  write address channel
- wvalid in 1 / wready out 1 / wdata in AXI_DATA_W / wstrb in AXI_DATA_W/8 / wlast in 1  write data channel
- bvalid out 1 / bready in 1 / bid out AXI_ID_W / bresp out 2  write response channel
- arvalid in 1 / arready out 1 / araddr in AXI_ADDR_W / arlen in 8 / arsize in 3 / arburst in 2 / arid in AXI_ID_W  read address channel
- rvalid out 1 / rready in 1 / rid out AXI_ID_W / rresp out 2 / rdata out AXI_DATA_W / rlast out 1  read data channel

Behaviour:
- Single clock aclk; reset srst is synchronous, active-high. While srst is high, every output is 0 (including awready/arready), both FSMs return to IDLE, and in-flight bursts and pending responses are dropped. Memory contents are not reset.
- Word index = addr[ADDR_LSB +: log2(MEM_DEPTH)], where ADDR_LSB = log2(AXI_DATA_W/8). Low address bits and a/size are ignored; byte lanes are selected only by wstrb.
- Range check on base address only: addr >> ADDR_LSB >= MEM_DEPTH gives an out-of-range (OOR) burst.
- Burst addressing:
  - awburst/arburst 2'b01 (INCR), 2'b10 and 2'b11: index +1 per beat, wraps modulo MEM_DEPTH.
  - 2'b00 (FIXED): index constant.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: awready=1. On awvalid&awready, latch index, awlen, awid, burst and OOR flag, beat counter = 0, go to W_DATA.
  - W_DATA: wready=1. Each wvalid&wready writes wdata bytes whose wstrb bit is 1 (none if OOR) at the clock edge.
  - Last beat is the one with counter == len; counter alone ends the burst, wlast does not.
  - Set error flag if wlast=1 before the last beat or wlast=0 on the last beat; then go to W_RESP.
  - W_RESP: bvalid=1, bid=latched id, bresp=2'b10 (SLVERR) if OOR or wlast mismatch, else 2'b00. On bvalid&bready, return to W_IDLE.
  - Next AW is accepted the cycle after the B handshake.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: arready=1. On AR handshake at edge T, latch id/len/burst/OOR and register beat 0 data; rvalid=1 from T+1.
  - R_DATA: rdata = mem word (0 if OOR), rresp SLVERR if OOR else OKAY, rid = latched id, rlast=1 when beat == len.
  - On rvalid&rready, load the next beat in the same edge, giving one beat per cycle with rready held high.
  - rvalid, rdata, rlast, rresp stay stable while rready=0.
  - After the rlast handshake, return to R_IDLE (rvalid=0 next cycle).
- Both channels run concurrently.
- Same-word collision: if a W beat and a read-beat load occur on the same edge, the read returns the pre-write contents.
- awlen/arlen 0..255 give 1..256 beats; the counter is 8 bits and never overflows.

Test Plan:
- Single write awaddr=0x0010, wdata=128'h..._DEADBEEF, wstrb=16'h000F, wlast=1, awid=0x21 -> bvalid with bid=0x21, bresp=0. Then read araddr=0x0010, arlen=0 -> rdata[31:0]=0xDEADBEEF, other bytes unchanged, rlast=1, rvalid one cycle after AR handshake.
- INCR burst write awaddr=0x0100, awlen=3, wstrb all ones, data 1..4 -> bresp OKAY. Read arlen=3 -> 4 back-to-back beats 1,2,3,4, rlast only on beat 4.
- Read burst arlen=1 with rready low for 3 cycles on beat 0 -> rdata/rvalid/rlast stable; beat 1 follows the cycle after rready rises.
- OOR with defaults (16 KB): awaddr=0x4000 -> bresp=2'b10, memory unchanged. araddr=0x4000 -> rresp=2'b10, rdata=0.
- Write awlen=2 with wlast=1 on beat 1 -> all 3 beats written, bresp=SLVERR.
- srst pulse in the middle of an awlen=7 write and arlen=7 read -> next cycle all outputs 0. After srst falls, awready=arready=1, and a new transfer completes correctly.

Source files
------------

// File: rtl/friscv_axi4_mem_slave.sv
// AXI4 slave with internal byte-addressable memory: independent write and read
// engines, one outstanding burst each, INCR/FIXED bursts up to 256 beats.
module friscv_axi4_mem_slave #(
    parameter int unsigned AXI_ADDR_W = 16,
    parameter int unsigned AXI_ID_W   = 8,
    parameter int unsigned AXI_DATA_W = 128,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic                    aclk,
    input  logic                    srst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [AXI_ADDR_W-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic [AXI_ID_W-1:0]     awid,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [AXI_DATA_W-1:0]   wdata,
    input  logic [AXI_DATA_W/8-1:0] wstrb,
    input  logic                    wlast,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [AXI_ID_W-1:0]     bid,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [AXI_ADDR_W-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic [AXI_ID_W-1:0]     arid,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [AXI_ID_W-1:0]     rid,
    output logic [1:0]              rresp,
    output logic [AXI_DATA_W-1:0]   rdata,
    output logic                    rlast
);

    localparam int unsigned STRB_W   = AXI_DATA_W / 8;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    logic [AXI_DATA_W-1:0] mem [MEM_DEPTH];

    // Only the base address is range-checked; bursts wrap inside the array.
    function automatic logic addr_oor(input logic [AXI_ADDR_W-1:0] a);
        logic [AXI_ADDR_W-1:0] hi;
        hi = a >> (ADDR_LSB + IDX_W);
        return |hi;
    endfunction

    wstate_t               wstate_q;
    logic                  awready_q, wready_q, bvalid_q;
    logic [AXI_ID_W-1:0]   bid_q;
    logic [1:0]            bresp_q;
    logic [IDX_W-1:0]      widx_q;
    logic [7:0]            wlen_q, wcnt_q;
    logic                  wfixed_q, woor_q, werr_q;
    logic                  mem_we;

    rstate_t               rstate_q;
    logic                  arready_q, rvalid_q, rlast_q;
    logic [AXI_ID_W-1:0]   rid_q;
    logic [1:0]            rresp_q;
    logic [AXI_DATA_W-1:0] rdata_q;
    logic [IDX_W-1:0]      ridx_q, ridx_d;
    logic [7:0]            rlen_q, rcnt_q;
    logic                  rfixed_q, roor_q;

    logic unused_bits;
    assign unused_bits = ^{awsize, arsize, awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};

    assign mem_we = !srst && (wstate_q == W_DATA) && wvalid && wready_q && !woor_q;

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (wstrb[b]) mem[widx_q][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Write engine: the beat counter alone ends the burst; wlast only flags errors.
    always_ff @(posedge aclk) begin
        if (srst) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            widx_q    <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wfixed_q  <= 1'b0;
            woor_q    <= 1'b0;
            werr_q    <= 1'b0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (awvalid && awready_q) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        widx_q    <= awaddr[ADDR_LSB +: IDX_W];
                        wlen_q    <= awlen;
                        bid_q     <= awid;
                        wfixed_q  <= (awburst == 2'b00);
                        woor_q    <= addr_oor(awaddr);
                        werr_q    <= 1'b0;
                        wcnt_q    <= '0;
                        wstate_q  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid && wready_q) begin
                        if (wcnt_q == wlen_q) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (woor_q || werr_q || !wlast) ? RESP_SLVERR : RESP_OKAY;
                            wstate_q <= W_RESP;
                        end else begin
                            wcnt_q <= 8'(wcnt_q + 8'd1);
                            if (!wfixed_q) widx_q <= widx_q + IDX_W'(1);
                            if (wlast) werr_q <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid_q && bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    assign ridx_d = rfixed_q ? ridx_q : ridx_q + IDX_W'(1);

    // Read engine: the next beat is fetched on the same edge as the R handshake.
    always_ff @(posedge aclk) begin
        if (srst) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            ridx_q    <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rfixed_q  <= 1'b0;
            roor_q    <= 1'b0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (arvalid && arready_q) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rid_q     <= arid;
                        rlen_q    <= arlen;
                        rcnt_q    <= '0;
                        rfixed_q  <= (arburst == 2'b00);
                        roor_q    <= addr_oor(araddr);
                        ridx_q    <= araddr[ADDR_LSB +: IDX_W];
                        rdata_q   <= addr_oor(araddr) ? '0 : mem[araddr[ADDR_LSB +: IDX_W]];
                        rresp_q   <= addr_oor(araddr) ? RESP_SLVERR : RESP_OKAY;
                        rlast_q   <= (arlen == 8'd0);
                        rstate_q  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid_q && rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            rresp_q   <= RESP_OKAY;
                            rdata_q   <= '0;
                            arready_q <= 1'b1;
                            rstate_q  <= R_IDLE;
                        end else begin
                            rcnt_q  <= 8'(rcnt_q + 8'd1);
                            ridx_q  <= ridx_d;
                            rdata_q <= roor_q ? '0 : mem[ridx_d];
                            rlast_q <= (8'(rcnt_q + 8'd1) == rlen_q);
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rid     = rid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;
    assign rlast   = rlast_q;

endmodule

// File: tb/tb_friscv_axi4_mem_slave.sv
// Directed bench for friscv_axi4_mem_slave: byte-array model with expected B/R
// queues checked every cycle, plus literal expectations per scenario.
module tb_friscv_axi4_mem_slave;

    localparam int unsigned AW = 16, IW = 8, DW = 128, SW = DW / 8, DEPTH = 1024;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01;

    logic          aclk = 1'b0;
    logic          srst = 1'b1;
    logic          awvalid = 1'b0, awready;
    logic [AW-1:0] awaddr = '0;
    logic [7:0]    awlen = '0;
    logic [2:0]    awsize = 3'd4;
    logic [1:0]    awburst = INCR;
    logic [IW-1:0] awid = '0;
    logic          wvalid = 1'b0, wready;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic          wlast = 1'b0;
    logic          bvalid, bready = 1'b1;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          arvalid = 1'b0, arready;
    logic [AW-1:0] araddr = '0;
    logic [7:0]    arlen = '0;
    logic [2:0]    arsize = 3'd4;
    logic [1:0]    arburst = INCR;
    logic [IW-1:0] arid = '0;
    logic          rvalid, rready = 1'b1;
    logic [IW-1:0] rid;
    logic [1:0]    rresp;
    logic [DW-1:0] rdata;
    logic          rlast;

    friscv_axi4_mem_slave dut (
        .aclk(aclk), .srst(srst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awid(awid),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rresp(rresp), .rdata(rdata), .rlast(rlast)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } rbeat_t;
    typedef struct {
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } bexp_t;

    int     checks = 0;
    int     failures = 0;
    bit     chk_en = 1'b0;
    logic [DW-1:0] mm [DEPTH];
    logic [DW-1:0] wd [256];
    rbeat_t exp_r[$];
    bexp_t  exp_b[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every cycle a response is valid it must match the head of the model queue.
    always @(negedge aclk) begin
        if (chk_en && !srst) begin
            if (rvalid) begin
                if (exp_r.size() == 0) chk("r_unexpected", rvalid, 1'b0);
                else begin
                    chk("r_data", rdata, exp_r[0].data);
                    chk("r_id",   rid,   exp_r[0].id);
                    chk("r_resp", rresp, exp_r[0].resp);
                    chk("r_last", rlast, exp_r[0].last);
                    if (rready) exp_r.delete(0);
                end
            end
            if (bvalid) begin
                if (exp_b.size() == 0) chk("b_unexpected", bvalid, 1'b0);
                else begin
                    chk("b_id",   bid,   exp_b[0].id);
                    chk("b_resp", bresp, exp_b[0].resp);
                    if (bready) exp_b.delete(0);
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_awready"}, awready, 0);
        chk({tag, "_wready"},  wready,  0);
        chk({tag, "_bvalid"},  bvalid,  0);
        chk({tag, "_bid"},     bid,     0);
        chk({tag, "_bresp"},   bresp,   0);
        chk({tag, "_arready"}, arready, 0);
        chk({tag, "_rvalid"},  rvalid,  0);
        chk({tag, "_rid"},     rid,     0);
        chk({tag, "_rresp"},   rresp,   0);
        chk({tag, "_rdata"},   rdata,   0);
        chk({tag, "_rlast"},   rlast,   0);
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                             input logic [IW-1:0] id, input logic [SW-1:0] strb, input int wlast_at,
                             output logic [IW-1:0] got_id, output logic [1:0] got_resp);
        int base, widx, n;
        bit oor;
        base = int'(addr >> 4);
        oor  = base >= DEPTH;
        exp_b.push_back('{id: id, resp: (oor || wlast_at != len) ? 2'b10 : 2'b00});
        awaddr = addr; awlen = 8'(len); awburst = burst; awid = id; awvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!awready && n < 100) begin @(negedge aclk); n++; end
        chk("aw_ready", awready, 1);
        @(posedge aclk); #1 awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1; wdata = wd[i]; wstrb = strb; wlast = (i == wlast_at);
            n = 0;
            @(negedge aclk);
            while (!wready && n < 100) begin @(negedge aclk); n++; end
            chk("w_ready", wready, 1);
            @(posedge aclk); #1;
            if (!oor) begin
                widx = (burst == FIXED) ? base % DEPTH : (base + i) % DEPTH;
                for (int b = 0; b < SW; b++) if (strb[b]) mm[widx][b*8 +: 8] = wd[i][b*8 +: 8];
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        @(negedge aclk);
        while (!bvalid && n < 100) begin @(negedge aclk); n++; end
        chk("b_valid", bvalid, 1);
        got_id = bid; got_resp = bresp;
        @(posedge aclk); #1;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                            input logic [IW-1:0] id, output logic [DW-1:0] d0, output logic [1:0] r0,
                            output logic l0, output int cycles);
        int base, ridx, n;
        bit oor;
        base = int'(addr >> 4);
        oor  = base >= DEPTH;
        for (int i = 0; i <= len; i++) begin
            ridx = (burst == FIXED) ? base % DEPTH : (base + i) % DEPTH;
            exp_r.push_back('{id: id, data: oor ? '0 : mm[ridx], resp: oor ? 2'b10 : 2'b00, last: (i == len)});
        end
        araddr = addr; arlen = 8'(len); arburst = burst; arid = id; arvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!arready && n < 100) begin @(negedge aclk); n++; end
        chk("ar_ready", arready, 1);
        @(posedge aclk); #1 arvalid = 1'b0;
        @(negedge aclk);
        chk("r_latency", rvalid, 1);
        d0 = rdata; r0 = rresp; l0 = rlast;
        cycles = 1;
        while (!(rvalid && rready && rlast) && cycles < 600) begin @(negedge aclk); cycles++; end
        @(posedge aclk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0] gi;
        logic [1:0]    gr, r0;
        logic [DW-1:0] d0;
        logic          l0;
        int            cyc;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_zero("rst");
        @(posedge aclk); #1 srst = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        chk("post_rst_awready", awready, 1);
        chk("post_rst_arready", arready, 1);
        chk_en = 1'b1;
        @(posedge aclk); #1;

        // Partial-strobe write over a known word.
        wd[0] = 128'h0123456789ABCDEF_FEDCBA9876543210;
        axi_write(16'h0010, 0, INCR, 8'h20, '1, 0, gi, gr);
        wd[0] = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_DEADBEEF;
        axi_write(16'h0010, 0, INCR, 8'h21, 16'h000F, 0, gi, gr);
        chk("t1_bid", gi, 8'h21);
        chk("t1_bresp", gr, 2'b00);
        axi_read(16'h0010, 0, INCR, 8'h41, d0, r0, l0, cyc);
        chk("t1_rdata", d0, 128'h0123456789ABCDEF_FEDCBA98DEADBEEF);
        chk("t1_rlast", l0, 1);

        // INCR burst, back-to-back read.
        for (int i = 0; i < 4; i++) wd[i] = DW'(i + 1);
        axi_write(16'h0100, 3, INCR, 8'h02, '1, 3, gi, gr);
        chk("t2_bresp", gr, 2'b00);
        axi_read(16'h0100, 3, INCR, 8'h03, d0, r0, l0, cyc);
        chk("t2_beat0", d0, 1);
        chk("t2_beat0_last", l0, 0);
        chk("t2_cycles", cyc, 4);

        // Read with rready held low for 3 cycles on beat 0.
        rready = 1'b0;
        exp_r.push_back('{id: 8'h04, data: mm[16'h0101 >> 4], resp: 2'b00, last: 1'b0});
        exp_r.push_back('{id: 8'h04, data: mm[(16'h0101 >> 4) + 1], resp: 2'b00, last: 1'b1});
        araddr = 16'h0100; arlen = 8'd1; arburst = INCR; arid = 8'h04; arvalid = 1'b1;
        @(negedge aclk);
        chk("t3_arready", arready, 1);
        @(posedge aclk); #1 arvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            chk("t3_stall_rvalid", rvalid, 1);
            chk("t3_stall_rdata", rdata, 1);
            chk("t3_stall_rlast", rlast, 0);
        end
        @(posedge aclk); #1 rready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        chk("t3_beat1_rdata", rdata, 2);
        chk("t3_beat1_rlast", rlast, 1);
        @(posedge aclk); #1;

        // Out-of-range base address.
        wd[0] = {4{32'h55AA55AA}};
        axi_write(16'h0000, 0, INCR, 8'h05, '1, 0, gi, gr);
        wd[0] = '1;
        axi_write(16'h4000, 0, INCR, 8'h06, '1, 0, gi, gr);
        chk("t4_bresp", gr, 2'b10);
        axi_read(16'h0000, 0, INCR, 8'h07, d0, r0, l0, cyc);
        chk("t4_mem_unchanged", d0, {4{32'h55AA55AA}});
        axi_read(16'h4000, 1, INCR, 8'h08, d0, r0, l0, cyc);
        chk("t4_rresp", r0, 2'b10);
        chk("t4_rdata", d0, 0);

        // Early wlast: all beats still land, response is SLVERR.
        wd[0] = 128'h11; wd[1] = 128'h22; wd[2] = 128'h33;
        axi_write(16'h0200, 2, INCR, 8'h09, '1, 1, gi, gr);
        chk("t5_bresp", gr, 2'b10);
        axi_read(16'h0200, 2, INCR, 8'h0A, d0, r0, l0, cyc);
        chk("t5_beat0", d0, 128'h11);

        // FIXED burst keeps the index; INCR burst wraps past the last word.
        wd[0] = 128'h5; wd[1] = 128'h6; wd[2] = 128'h7;
        axi_write(16'h0300, 2, FIXED, 8'h0B, '1, 2, gi, gr);
        axi_read(16'h0300, 2, FIXED, 8'h0C, d0, r0, l0, cyc);
        chk("t6_fixed", d0, 128'h7);
        wd[0] = 128'hA0; wd[1] = 128'hB0;
        axi_write(16'h3FF0, 1, INCR, 8'h0D, '1, 1, gi, gr);
        axi_read(16'h0000, 0, INCR, 8'h0E, d0, r0, l0, cyc);
        chk("t6_wrap", d0, 128'hB0);

        // Reset in the middle of an awlen=7 write and arlen=7 read.
        chk_en = 1'b0;
        awaddr = 16'h0500; awlen = 8'd7; awburst = INCR; awid = 8'h10; awvalid = 1'b1;
        araddr = 16'h0100; arlen = 8'd7; arburst = INCR; arid = 8'h11; arvalid = 1'b1;
        @(negedge aclk);
        chk("t7_awready", awready, 1);
        chk("t7_arready", arready, 1);
        @(posedge aclk); #1 awvalid = 1'b0; arvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wvalid = 1'b1; wdata = DW'(i); wstrb = '1; wlast = 1'b0;
            @(posedge aclk); #1;
        end
        srst = 1'b1; wvalid = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check_zero("mid_rst");
        @(posedge aclk); #1 srst = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        chk("t7_post_awready", awready, 1);
        chk("t7_post_arready", arready, 1);
        exp_r.delete();
        exp_b.delete();
        chk_en = 1'b1;
        @(posedge aclk); #1;
        wd[0] = 128'hC0FFEE; wd[1] = 128'hBADC0DE;
        axi_write(16'h0600, 1, INCR, 8'h33, '1, 1, gi, gr);
        chk("t7_bid", gi, 8'h33);
        chk("t7_bresp", gr, 2'b00);
        axi_read(16'h0600, 1, INCR, 8'h34, d0, r0, l0, cyc);
        chk("t7_rdata", d0, 128'hC0FFEE);
        chk("t7_cycles", cyc, 2);

        repeat (3) @(posedge aclk);
        chk("exp_r_drained", exp_r.size(), 0);
        chk("exp_b_drained", exp_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
